// File: rtl/proc_hier_pkg.sv
// Shared constants and commit record for the processor observation hub.
// Cache statistics are built only when PROC_HIER_CACHE_STATS_EN is defined.
package proc_hier_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int REG_W     = 3;
  localparam int DATA_W    = 16;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } commit_t;

endpackage

// File: rtl/proc_hier_top_sat_counter.sv
// Enabled saturating counter with async active-low clear and hold.
// Used for every statistics counter in proc_hier_top.
module sat_counter
  import proc_hier_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] q_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !hold_i && (cnt_q != '1))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/proc_hier_top.sv
// Commit qualification and statistics hub beside the pipelined core.
// Define PROC_HIER_CACHE_STATS_EN to build the four cache counters.
module proc_hier_top
  import proc_hier_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_write_en,
  input  logic [REG_W-1:0]  wb_write_sel,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              mem_stall,
  input  logic              fwd_stall,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt_in,
  input  logic              ic_stall,
  input  logic              ic_done,
  input  logic              ic_hit,
  input  logic              dc_stall,
  input  logic              dc_rd,
  input  logic              dc_wr,
  input  logic              dc_done,
  input  logic              dc_hit,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              halted,
  output logic              summary_valid,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  ic_req_count,
  output logic [CNT_W-1:0]  ic_hit_count,
  output logic [CNT_W-1:0]  dc_req_count,
  output logic [CNT_W-1:0]  dc_hit_count
);

  logic    halted_q, halted_d;
  logic    summ_q, summ_d;
  logic    inst_ev;
  commit_t commit;
  logic    unused_trace;

  assign reg_write = wb_write_en & ~mem_stall
                   & ~fwd_stall & ~halted_q;
  assign mem_read  = mem_en & ~mem_wr & ~mem_stall
                   & ~fwd_stall & ~halted_q;
  assign mem_write = mem_wr & ~mem_stall & ~halted_q;
  assign inst_ev   = halt_in | reg_write | mem_write;

  // Trace-side record; consumed outside this block.
  assign commit = '{valid: reg_write,
                    sel:   wb_write_sel,
                    data:  wb_write_data};
  assign unused_trace = ^{commit, mem_addr,
                          mem_wdata, mem_rdata};

  always_comb begin
    halted_d = halted_q | halt_in;
    summ_d   = halt_in & ~halted_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      summ_q   <= 1'b0;
    end else begin
      halted_q <= halted_d;
      summ_q   <= summ_d;
    end
  end

  assign halted        = halted_q;
  assign summary_valid = summ_q;

  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .rst_n(rst_n), .en_i(1'b1),
    .hold_i(halted_q), .q_o(cycle_count));

  sat_counter #(.CNT_W(CNT_W)) u_inst (
    .clk(clk), .rst_n(rst_n), .en_i(inst_ev),
    .hold_i(halted_q), .q_o(inst_count));

`ifdef PROC_HIER_CACHE_STATS_EN
  logic ic_req, ic_hitev, dc_req, dc_hitev;

  assign ic_req   = ~ic_stall;
  assign ic_hitev = ic_done & ic_hit;
  assign dc_req   = ~dc_stall & (dc_rd | dc_wr);
  assign dc_hitev = dc_done & dc_hit;

  sat_counter #(.CNT_W(CNT_W)) u_icr (
    .clk(clk), .rst_n(rst_n), .en_i(ic_req),
    .hold_i(halted_q), .q_o(ic_req_count));

  sat_counter #(.CNT_W(CNT_W)) u_ich (
    .clk(clk), .rst_n(rst_n), .en_i(ic_hitev),
    .hold_i(halted_q), .q_o(ic_hit_count));

  sat_counter #(.CNT_W(CNT_W)) u_dcr (
    .clk(clk), .rst_n(rst_n), .en_i(dc_req),
    .hold_i(halted_q), .q_o(dc_req_count));

  sat_counter #(.CNT_W(CNT_W)) u_dch (
    .clk(clk), .rst_n(rst_n), .en_i(dc_hitev),
    .hold_i(halted_q), .q_o(dc_hit_count));
`else
  logic unused_cache;

  assign unused_cache = ^{ic_stall, ic_done, ic_hit,
                          dc_stall, dc_rd, dc_wr,
                          dc_done, dc_hit};
  assign ic_req_count = '0;
  assign ic_hit_count = '0;
  assign dc_req_count = '0;
  assign dc_hit_count = '0;
`endif

endmodule

// File: tb/tb_proc_hier_top.sv
// Randomized self-checking bench for proc_hier_top (32-bit and 4-bit builds).
// Cache counter expectations follow PROC_HIER_CACHE_STATS_EN.
module tb_proc_hier_top;

`ifdef PROC_HIER_CACHE_STATS_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct packed {
    logic wb_en, mem_stall, fwd_stall, mem_en, mem_wr, halt;
    logic ic_stall, ic_done, ic_hit;
    logic dc_stall, dc_rd, dc_wr, dc_done, dc_hit;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_write_en, mem_stall, fwd_stall, mem_en, mem_wr, halt_in;
  logic ic_stall, ic_done, ic_hit;
  logic dc_stall, dc_rd, dc_wr, dc_done, dc_hit;
  logic [2:0]  wb_write_sel;
  logic [15:0] wb_write_data, mem_addr, mem_wdata, mem_rdata;

  logic rw_a, mr_a, mw_a, h_a, sv_a;
  logic [31:0] cyc_a, ins_a, icr_a, ich_a, dcr_a, dch_a;
  logic rw_b, mr_b, mw_b, h_b, sv_b;
  logic [3:0] cyc_b, ins_b, icr_b, ich_b, dcr_b, dch_b;

  int checks = 0;
  int errors = 0;

  longint m_cyc, m_ins, m_icr, m_ich, m_dcr, m_dch;
  bit m_halted, m_sum;
  int obs_rw, obs_mr, obs_mw;

  always #5 clk = ~clk;

  proc_hier_top #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_write_en(wb_write_en), .wb_write_sel(wb_write_sel),
    .wb_write_data(wb_write_data), .mem_stall(mem_stall),
    .fwd_stall(fwd_stall), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halt_in(halt_in),
    .ic_stall(ic_stall), .ic_done(ic_done), .ic_hit(ic_hit),
    .dc_stall(dc_stall), .dc_rd(dc_rd), .dc_wr(dc_wr),
    .dc_done(dc_done), .dc_hit(dc_hit),
    .reg_write(rw_a), .mem_read(mr_a), .mem_write(mw_a),
    .halted(h_a), .summary_valid(sv_a),
    .cycle_count(cyc_a), .inst_count(ins_a),
    .ic_req_count(icr_a), .ic_hit_count(ich_a),
    .dc_req_count(dcr_a), .dc_hit_count(dch_a));

  proc_hier_top #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .wb_write_en(wb_write_en), .wb_write_sel(wb_write_sel),
    .wb_write_data(wb_write_data), .mem_stall(mem_stall),
    .fwd_stall(fwd_stall), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .halt_in(halt_in),
    .ic_stall(ic_stall), .ic_done(ic_done), .ic_hit(ic_hit),
    .dc_stall(dc_stall), .dc_rd(dc_rd), .dc_wr(dc_wr),
    .dc_done(dc_done), .dc_hit(dc_hit),
    .reg_write(rw_b), .mem_read(mr_b), .mem_write(mw_b),
    .halted(h_b), .summary_valid(sv_b),
    .cycle_count(cyc_b), .inst_count(ins_b),
    .ic_req_count(icr_b), .ic_hit_count(ich_b),
    .dc_req_count(dcr_b), .dc_hit_count(dch_b));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic longint cs(input longint v);
    return CS ? v : 0;
  endfunction

  task automatic check_state();
    chk("cyc", cyc_a, m_cyc);
    chk("inst", ins_a, m_ins);
    chk("icr", icr_a, cs(m_icr));
    chk("ich", ich_a, cs(m_ich));
    chk("dcr", dcr_a, cs(m_dcr));
    chk("dch", dch_a, cs(m_dch));
    chk("halted", h_a, m_halted);
    chk("summary", sv_a, m_sum);
    chk("cyc4", cyc_b, sat4(m_cyc));
    chk("inst4", ins_b, sat4(m_ins));
    chk("icr4", icr_b, sat4(cs(m_icr)));
    chk("ich4", ich_b, sat4(cs(m_ich)));
    chk("dcr4", dcr_b, sat4(cs(m_dcr)));
    chk("dch4", dch_b, sat4(cs(m_dch)));
    chk("halted4", h_b, m_halted);
    chk("summary4", sv_b, m_sum);
  endtask

  task automatic model_clear();
    m_cyc = 0; m_ins = 0; m_icr = 0;
    m_ich = 0; m_dcr = 0; m_dch = 0;
    m_halted = 0; m_sum = 0;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.ic_stall = 1'b1;
    s.dc_stall = 1'b1;
    return s;
  endfunction

  // Called at a falling edge; covers exactly one rising edge.
  task automatic step(input stim_t s);
    bit e_rw, e_mr, e_mw;
    wb_write_en = s.wb_en;   mem_stall = s.mem_stall;
    fwd_stall = s.fwd_stall; mem_en = s.mem_en;
    mem_wr = s.mem_wr;       halt_in = s.halt;
    ic_stall = s.ic_stall;   ic_done = s.ic_done;
    ic_hit = s.ic_hit;       dc_stall = s.dc_stall;
    dc_rd = s.dc_rd;         dc_wr = s.dc_wr;
    dc_done = s.dc_done;     dc_hit = s.dc_hit;
    wb_write_sel = 3'($urandom);
    wb_write_data = 16'($urandom);
    mem_addr = 16'($urandom);
    mem_wdata = 16'($urandom);
    mem_rdata = 16'($urandom);
    #1;
    e_rw = !m_halted && s.wb_en && !s.mem_stall && !s.fwd_stall;
    e_mr = !m_halted && s.mem_en && !s.mem_wr
           && !s.mem_stall && !s.fwd_stall;
    e_mw = !m_halted && s.mem_wr && !s.mem_stall;
    chk("reg_write", rw_a, e_rw);
    chk("mem_read", mr_a, e_mr);
    chk("mem_write", mw_a, e_mw);
    chk("reg_write4", rw_b, e_rw);
    obs_rw += int'(rw_a);
    obs_mr += int'(mr_a);
    obs_mw += int'(mw_a);
    m_sum = s.halt && !m_halted;
    if (!m_halted) begin
      m_cyc++;
      if (s.halt || e_rw || e_mw) m_ins++;
      if (!s.ic_stall) m_icr++;
      if (s.ic_done && s.ic_hit) m_ich++;
      if (!s.dc_stall && (s.dc_rd || s.dc_wr)) m_dcr++;
      if (s.dc_done && s.dc_hit) m_dch++;
    end
    m_halted = m_halted || s.halt;
    @(negedge clk);
    check_state();
  endtask

  initial begin
    stim_t s;
    model_clear();
    s = idle();
    step_inputs_idle: begin
      wb_write_en = 0; mem_stall = 0; fwd_stall = 0;
      mem_en = 0; mem_wr = 0; halt_in = 0;
      ic_stall = 1; ic_done = 0; ic_hit = 0;
      dc_stall = 1; dc_rd = 0; dc_wr = 0;
      dc_done = 0; dc_hit = 0;
      wb_write_sel = 0; wb_write_data = 0;
      mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_state();

    repeat (10) step(idle());
    chk("lit_idle_cyc", cyc_a, 10);
    chk("lit_idle_inst", ins_a, 0);

    obs_rw = 0;
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.wb_en = 1; s.mem_stall = (i == 1);
      step(s);
    end
    chk("lit_rw_pulses", obs_rw, 3);
    chk("lit_rw_inst", ins_a, 3);

    obs_mr = 0;
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mem_en = 1; s.fwd_stall = (i == 1);
      step(s);
    end
    chk("lit_mr_pulses", obs_mr, 2);
    obs_mw = 0;
    s = idle(); s.mem_en = 1; s.mem_wr = 1; s.mem_stall = 1;
    step(s);
    chk("lit_stalled_store", obs_mw, 0);

    for (int i = 0; i < 8; i++) begin
      s = idle(); s.ic_stall = 0;
      s.ic_done = (i < 5); s.ic_hit = (i < 5);
      s.dc_rd = (i < 3); s.dc_stall = (i == 1);
      s.dc_done = (i == 4); s.dc_hit = (i == 4);
      step(s);
    end
    chk("lit_icr", icr_a, CS ? 8 : 0);
    chk("lit_ich", ich_a, CS ? 5 : 0);
    chk("lit_dcr", dcr_a, CS ? 2 : 0);
    chk("lit_dch", dch_a, CS ? 1 : 0);

    s = idle(); s.halt = 1;
    step(s);
    chk("lit_halt_cyc", cyc_a, 27);
    chk("lit_halt_inst", ins_a, 4);
    chk("lit_summary_on", sv_a, 1);
    step(idle());
    chk("lit_summary_off", sv_a, 0);
    for (int i = 0; i < 5; i++) begin
      s = stim_t'($urandom); s.halt = 1;
      step(s);
    end
    chk("lit_frozen_cyc", cyc_a, 27);
    chk("lit_sat4_cyc", cyc_b, 15);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_state();
    chk("lit_rst_cyc", cyc_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_state();

    for (int i = 0; i < 400; i++) begin
      s = stim_t'($urandom);
      s.halt = ($urandom_range(0, 99) == 0);
      step(s);
      if (m_halted && ($urandom_range(0, 7) == 0)) begin
        #2 rst_n = 1'b0;
        #1 model_clear();
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
